// File: rtl/pipelined_mux_if.sv
// Bundles the pipelined multiplexer's stream signals.
// The master drives the channel bus, the select, the strobes and the enable; the slave returns the registered word.
interface pipelined_mux_if #(
  parameter int SELECT_LINES = 4,
  parameter int DATA_WIDTH   = 8
);
  logic                                    en;
  logic [SELECT_LINES-1:0]                 select;
  logic [(2**SELECT_LINES)*DATA_WIDTH-1:0] data_in;
  logic                                    data_in_valid;
  logic                                    sync_in;
  logic [DATA_WIDTH-1:0]                   data_out;
  logic                                    data_out_valid;
  logic [SELECT_LINES-1:0]                 select_out;
  logic                                    sync_out;

  modport master (
    output en, select, data_in, data_in_valid, sync_in,
    input  data_out, data_out_valid, select_out, sync_out
  );

  modport slave (
    input  en, select, data_in, data_in_valid, sync_in,
    output data_out, data_out_valid, select_out, sync_out
  );
endinterface

// File: rtl/pipelined_mux.sv
// Registered 2**SELECT_LINES:1 word multiplexer with a LATENCY-deep pipeline.
// An optional round-robin channel counter can be resynchronised by sync_in.
module pipelined_mux #(
  parameter string ARCHITECTURE = "BEHAVIORAL",
  parameter int    SELECT_LINES = 4,
  parameter int    DATA_WIDTH   = 8,
  parameter int    LATENCY      = 1,
  parameter string SELECT_MODE  = "EXTERNAL"
) (
  input  logic            clk,
  input  logic            rst,
  pipelined_mux_if.slave  bus
);

  localparam bit RR = (SELECT_MODE == "ROUND_ROBIN");

  if (ARCHITECTURE != "BEHAVIORAL") begin : g_bad_arch
    $error("pipelined_mux: unsupported ARCHITECTURE");
  end
  if (SELECT_MODE != "EXTERNAL" && SELECT_MODE != "ROUND_ROBIN") begin : g_bad_mode
    $error("pipelined_mux: unknown SELECT_MODE");
  end
  if (SELECT_LINES < 1 || DATA_WIDTH < 1 || LATENCY < 1 || LATENCY > 16) begin : g_bad_param
    $error("pipelined_mux: parameter out of range");
  end

  logic [SELECT_LINES-1:0] rr_cnt_q, rr_cnt_d;
  logic [SELECT_LINES-1:0] sel_eff;
  logic [DATA_WIDTH-1:0]   word_sel;

  logic [DATA_WIDTH-1:0]   data_q [LATENCY];
  logic [SELECT_LINES-1:0] sel_q  [LATENCY];
  logic [LATENCY-1:0]      vld_q;
  logic [LATENCY-1:0]      sync_q;

  // A sync word is always tagged channel 0, so the counter restarts at 1 behind it.
  always_comb begin
    sel_eff  = RR ? (bus.sync_in ? '0 : rr_cnt_q) : bus.select;
    word_sel = bus.data_in[sel_eff*DATA_WIDTH +: DATA_WIDTH];
    rr_cnt_d = rr_cnt_q;
    if (bus.sync_in) begin
      rr_cnt_d = bus.data_in_valid ? SELECT_LINES'(1) : '0;
    end else if (bus.data_in_valid) begin
      rr_cnt_d = rr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_cnt_q <= '0;
      vld_q    <= '0;
      sync_q   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
        sel_q[i]  <= '0;
      end
    end else if (bus.en) begin
      rr_cnt_q  <= rr_cnt_d;
      // stage 0: capture the selected word
      vld_q[0]  <= bus.data_in_valid;
      sync_q[0] <= bus.sync_in;
      if (bus.data_in_valid) begin
        data_q[0] <= word_sel;
        sel_q[0]  <= sel_eff;
      end
      // stages 1..LATENCY-1: word registers load only behind a valid strobe
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        sync_q[i] <= sync_q[i-1];
        if (vld_q[i-1]) begin
          data_q[i] <= data_q[i-1];
          sel_q[i]  <= sel_q[i-1];
        end
      end
    end
  end

  assign bus.data_out       = data_q[LATENCY-1];
  assign bus.select_out     = sel_q[LATENCY-1];
  assign bus.data_out_valid = vld_q[LATENCY-1];
  assign bus.sync_out       = sync_q[LATENCY-1];

endmodule
